// File: rtl/timer_bank_pkg.sv
// Shared constants for the timer bank: word width, control bit offsets and
// the register map used by the board glue to derive strobes from r_load/r_read.
package timer_bank_pkg;
  localparam int WORD_W       = 16;
  localparam int RUN_LSB      = 0;
  localparam int PERIODIC_LSB = 8;

  // Register offsets on the MCU bus; count registers follow REG_COUNT0.
  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_STATUS = 4'h1;
  localparam logic [3:0] REG_COUNT0 = 4'h2;
endpackage

// File: rtl/timer_bank_if.sv
// Register-bus side of the timer bank: write data, load/read strobes, readback.
interface timer_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16
);
  logic [15:0]             data_in;
  logic [NUM_CH-1:0]       count_load;
  logic                    ctrl_load;
  logic                    status_read;
  logic [NUM_CH*WIDTH-1:0] count_out;
  logic [15:0]             ctrl_out;
  logic [15:0]             status_out;

  modport master (
    output data_in, count_load, ctrl_load, status_read,
    input  count_out, ctrl_out, status_out
  );
  modport slave (
    input  data_in, count_load, ctrl_load, status_read,
    output count_out, ctrl_out, status_out
  );
endinterface

// File: rtl/timer_bank_channel.sv
// One countdown channel: load has priority over the tick, count=1 on a tick
// expires (reload or stop), count=0 is an idle hold so the decrement never wraps.
module timer_channel #(
  parameter int WIDTH = 16
) (
  input  logic             sysclk,
  input  logic             sysreset,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             run,
  input  logic             periodic,
  output logic [WIDTH-1:0] count,
  output logic             expire,
  output logic             hit,
  output logic             run_clr
);
  logic [WIDTH-1:0] reload;

  // Expiry event in the current cycle; a same-cycle load suppresses it.
  assign hit     = tick & run & ~load & (count == WIDTH'(1));
  assign run_clr = hit & ~periodic;

  // Reload/count update and the registered one-cycle expiry pulse.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      reload <= '0;
      count  <= '0;
      expire <= 1'b0;
    end else begin
      expire <= hit;
      if (load) begin
        reload <= data;
        count  <= data;
      end else if (tick && run && count != '0) begin
        if (hit) count <= periodic ? reload : '0;
        else     count <= count - 1'b1;
      end
    end
  end
endmodule

// File: rtl/timer_bank.sv
// Multi-channel countdown timer bank: shared prescaler, control and sticky
// status registers, and NUM_CH countdown channels.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int WIDTH    = 16,
  parameter int PRESCALE = 50
) (
  input  logic              sysclk,
  input  logic              sysreset,
  input  logic              tick_enable,
  timer_bank_if.slave       bus,
  output logic [NUM_CH-1:0] expired,
  output logic              tick
);
  localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

  logic [15:0]                  ps;
  logic [NUM_CH-1:0]            run, per, hit, run_clr, status;
  logic [NUM_CH-1:0][WIDTH-1:0] cnt;

  assign tick = tick_enable && (ps == PS_MAX);

  // Prescaler: free-runs 0..PRESCALE-1 while enabled, holds when frozen.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset)         ps <= '0;
    else if (tick_enable) ps <= tick ? '0 : ps + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(.WIDTH(WIDTH)) u_ch (
      .sysclk   (sysclk),
      .sysreset (sysreset),
      .tick     (tick),
      .load     (bus.count_load[i]),
      .data     (bus.data_in[WIDTH-1:0]),
      .run      (run[i]),
      .periodic (per[i]),
      .count    (cnt[i]),
      .expire   (expired[i]),
      .hit      (hit[i]),
      .run_clr  (run_clr[i])
    );
  end

  // Control register: a bus write overrides a same-cycle one-shot auto-clear.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      run <= '0;
      per <= '0;
    end else if (bus.ctrl_load) begin
      run <= bus.data_in[RUN_LSB +: NUM_CH];
      per <= bus.data_in[PERIODIC_LSB +: NUM_CH];
    end else begin
      run <= run & ~run_clr;
    end
  end

  // Sticky status: read clears, but a same-edge expiry sets and wins.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) status <= '0;
    else          status <= (bus.status_read ? '0 : status) | hit;
  end

  // Control readback with unused bits forced to zero.
  always_comb begin
    bus.ctrl_out = '0;
    bus.ctrl_out[RUN_LSB +: NUM_CH]      = run;
    bus.ctrl_out[PERIODIC_LSB +: NUM_CH] = per;
  end

  assign bus.status_out = WORD_W'(status);
  assign bus.count_out  = cnt;
endmodule

// File: tb/tb_timer_bank.sv
// Bench for timer_bank: DUT a (PRESCALE=50) checked by a tick predictor plus an
// expiry scoreboard; DUT b (PRESCALE=1) covers the every-tick reload=1 case.
module tb_timer_bank;
  localparam int NCH = 4;
  localparam int W   = 16;
  localparam int PS  = 50;

  logic sysclk = 1'b0;
  logic sysreset = 1'b1;
  logic tick_enable = 1'b1;
  logic [NCH-1:0] exp_a, exp_b;
  logic tick_a, tick_b;

  timer_bank_if #(.NUM_CH(NCH), .WIDTH(W)) ba ();
  timer_bank_if #(.NUM_CH(NCH), .WIDTH(W)) bb ();

  timer_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(PS)) dut_a (
    .sysclk(sysclk), .sysreset(sysreset), .tick_enable(tick_enable),
    .bus(ba), .expired(exp_a), .tick(tick_a));

  timer_bank #(.NUM_CH(NCH), .WIDTH(W), .PRESCALE(1)) dut_b (
    .sysclk(sysclk), .sysreset(sysreset), .tick_enable(tick_enable),
    .bus(bb), .expired(exp_b), .tick(tick_b));

  always #5 sysclk = ~sysclk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Scoreboard of expected expiries: channel and the tick index that fires it.
  typedef struct { int ch; int tk; } exp_t;
  exp_t q[$];

  int ecnt = 0;      // enabled cycles since reset release
  int tick_idx = 0;  // ticks completed
  bit prev_pt = 0;   // previous cycle was a tick

  function automatic bit pred_now();
    return tick_enable && (ecnt % PS == PS - 1);
  endfunction

  function automatic logic [15:0] cnt(input int i);
    return ba.count_out[i*W +: W];
  endfunction

  // Bench-side time base advanced at each edge.
  always @(posedge sysclk) begin
    if (sysreset) begin
      ecnt = 0; tick_idx = 0; prev_pt = 0;
    end else begin
      prev_pt = pred_now();
      if (tick_enable) ecnt++;
      if (prev_pt) tick_idx++;
    end
  end

  // Per-cycle check of tick and the expiry pulses against the scoreboard.
  always @(negedge sysclk) begin
    logic [NCH-1:0] want;
    if (!sysreset) begin
      chk("tick", tick_a, pred_now());
      want = '0;
      if (prev_pt)
        while (q.size() > 0 && q[0].tk == tick_idx) begin
          want[q[0].ch] = 1'b1;
          void'(q.pop_front());
        end
      if (q.size() > 0 && q[0].tk <= tick_idx) begin
        chk("exp_missed_tick", 64'(q[0].tk), 64'(tick_idx + 1));
        void'(q.pop_front());
      end
      chk("expired", exp_a, want);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin @(posedge sysclk); #1; end
  endtask

  task automatic push(input int ch, input int tk);
    q.push_back('{ch: ch, tk: tk});
  endtask

  task automatic wr_ctrl(input logic [15:0] v);
    ba.ctrl_load = 1'b1; ba.data_in = v;
    step(1);
    ba.ctrl_load = 1'b0;
  endtask

  task automatic rd_status();
    ba.status_read = 1'b1;
    step(1);
    ba.status_read = 1'b0;
  endtask

  // Load a channel; b = ticks already counted, including a tick this cycle.
  task automatic ld(input int ch, input logic [15:0] v, output int b);
    ba.count_load = '0; ba.count_load[ch] = 1'b1; ba.data_in = v;
    b = tick_idx + int'(pred_now());
    step(1);
    ba.count_load = '0;
  endtask

  initial begin
    int b, last;
    bit ok;
    ba.data_in = '0; ba.count_load = '0; ba.ctrl_load = 1'b0; ba.status_read = 1'b0;
    bb.data_in = '0; bb.count_load = '0; bb.ctrl_load = 1'b0; bb.status_read = 1'b0;

    // Reset state
    step(2);
    chk("rst_count", ba.count_out, 0);
    chk("rst_ctrl", ba.ctrl_out, 0);
    chk("rst_status", ba.status_out, 0);
    chk("rst_exp", exp_a, 0);
    chk("rst_tick", tick_a, 0);
    sysreset = 1'b0;
    step(17);

    // One-shot ch0 = 3
    wr_ctrl(16'h0001);
    ld(0, 16'd3, b);
    push(0, b + 3);
    chk("os_load", cnt(0), 3);
    step(250);
    chk("os_count", cnt(0), 0);
    chk("os_ctrl", ba.ctrl_out, 0);
    chk("os_status", ba.status_out, 16'h0001);
    rd_status();
    chk("os_clr", ba.status_out, 0);

    // Periodic ch1 = 2: sequence 2,1,2,1..., status clear between expiries
    wr_ctrl(16'h0202);
    ld(1, 16'd2, b);
    for (int k = 2; k <= 8; k += 2) push(1, b + k);
    chk("per_load", cnt(1), 2);
    last = tick_idx; ok = 0;
    for (int k = 0; k < 1000; k++) begin
      step(1);
      if (tick_idx != last) begin
        last = tick_idx;
        chk("per_seq", cnt(1), ((tick_idx - b) % 2) ? 1 : 2);
        if (tick_idx == b + 3) begin
          chk("per_sticky", ba.status_out, 16'h0002);
          rd_status();
          chk("per_rdclr", ba.status_out, 0);
        end
        if (tick_idx == b + 4) chk("per_reset", ba.status_out, 16'h0002);
        if (tick_idx == b + 9) begin
          wr_ctrl(16'h0000);
          ok = 1;
          break;
        end
      end
    end
    chk("per_bound", ok, 1);
    chk("per_stop_ctrl", ba.ctrl_out, 0);
    step(150);
    chk("per_hold", cnt(1), 1);
    rd_status();

    // Freeze mid-count
    wr_ctrl(16'h0001);
    ld(0, 16'd5, b);
    push(0, b + 5);
    ok = 0;
    for (int k = 0; k < 400; k++) begin
      if (tick_idx == b + 2) begin ok = 1; break; end
      step(1);
    end
    chk("frz_bound", ok, 1);
    step(10);
    chk("frz_pre", cnt(0), 3);
    tick_enable = 1'b0;
    step(500);
    chk("frz_hold", cnt(0), 3);
    tick_enable = 1'b1;
    step(200);
    chk("frz_done", cnt(0), 0);
    chk("frz_status", ba.status_out, 16'h0001);
    rd_status();

    // Load on a tick cycle with count=1, then load 0 with RUN set
    wr_ctrl(16'h0004);
    ld(2, 16'd2, b);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (tick_idx == b + 1 && pred_now()) begin ok = 1; break; end
      step(1);
    end
    chk("sim_bound", ok, 1);
    chk("sim_pre", cnt(2), 1);
    ld(2, 16'd9, b);
    chk("sim_load", cnt(2), 9);
    ld(2, 16'd0, b);
    step(300);
    chk("zero_count", cnt(2), 0);
    chk("zero_ctrl", ba.ctrl_out, 16'h0004);
    chk("zero_status", ba.status_out, 0);

    // status_read on the expiry edge: set wins
    wr_ctrl(16'h0008);
    ld(3, 16'd1, b);
    push(3, b + 1);
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (pred_now()) begin ok = 1; break; end
      step(1);
    end
    chk("rdx_bound", ok, 1);
    rd_status();
    chk("rdx_status", ba.status_out, 16'h0008);
    chk("rdx_ctrl", ba.ctrl_out, 0);
    rd_status();

    // Async reset mid-count
    wr_ctrl(16'h0001);
    ld(0, 16'd7, b);
    push(0, b + 7);
    step(120);
    @(negedge sysclk); #2;
    sysreset = 1'b1;
    #1;
    chk("arst_count", ba.count_out, 0);
    chk("arst_ctrl", ba.ctrl_out, 0);
    chk("arst_exp", exp_a, 0);
    chk("arst_tick", tick_a, 0);
    q.delete();
    step(1);
    sysreset = 1'b0;
    chk("arst_rel", ba.count_out, 0);
    step(500);
    chk("arst_idle", ba.count_out, 0);
    chk("arst_idle_st", ba.status_out, 0);

    // PRESCALE=1, reload 1 periodic: expired high every cycle after the first
    bb.ctrl_load = 1'b1; bb.data_in = 16'h0101;
    step(1);
    bb.ctrl_load = 1'b0; bb.count_load = 4'b0001; bb.data_in = 16'd1;
    step(1);
    bb.count_load = '0;
    chk("p1_first", exp_b, 0);
    chk("p1_tick", tick_b, 1);
    step(1);
    for (int k = 0; k < 10; k++) begin
      chk("p1_exp", exp_b, 4'b0001);
      chk("p1_cnt", bb.count_out[W-1:0], 1);
      step(1);
    end
    chk("p1_status", bb.status_out, 16'h0001);

    chk("sb_empty", 64'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Multi-channel countdown timer bank. Parametrised successor to the fixed sysclk/50 prescaler and chained cdtimer16 dividers in the board top level.
- One shared prescaler generates the tick. NUM_CH independent countdown channels each support one-shot or periodic mode, a per-channel expiry pulse, and a read-to-clear sticky status.
- Sits on the target MCU register bus. Per-register load and read strobes come from the r_load and r_read vectors. tick_enable is driven from the supervisor break-mode negation so timers freeze while the debugger holds the MCU.

Parameters:
- NUM_CH, 4: number of countdown channels. Legal range 1..8, so that the run and mode fields fit one 16-bit control word.
- WIDTH, 16: counter and reload width in bits. Legal range 2..16.
- PRESCALE, 50: sysclk cycles per tick. Legal range 1..65535. A value of 1 means a tick on every enabled cycle.

Ports:
- sysclk  in  1  system clock; all logic rises on posedge.
- sysreset  in  1  asynchronous, active-high reset.
- tick_enable  in  1  gates the prescaler; 0 freezes all timing.
- data_in  in  16  bus write data (r_load_data).
- count_load  in  NUM_CH  per-channel write strobe; loads both reload and count from data_in[WIDTH-1:0].
- ctrl_load  in  1  control register write strobe.
- status_read  in  1  status register read strobe; clears sticky flags.
- count_out  out  NUM_CH*WIDTH  live counts, channel i at [i*WIDTH +: WIDTH].
- ctrl_out  out  16  control register readback.
- status_out  out  16  sticky expiry flags in [NUM_CH-1:0]; upper bits 0.
- expired  out  NUM_CH  one-cycle expiry pulses.
- tick  out  1  prescaler pulse, one cycle wide.

Behaviour:
- Reset (async, any time, including mid-count):
  - prescaler, all counts, all reloads, ctrl, status, expired and tick go to 0 immediately.
  - Outputs stay 0 until the first clock edge after sysreset falls.
- Control word layout:
  - bits [NUM_CH-1:0] RUN[i].
  - bits [8+NUM_CH-1:8] PERIODIC[i].
  - All other bits are written as ignored and read back as 0.
- Prescaler:
  - When tick_enable=1, it counts 0..PRESCALE-1.
  - The tick cycle is the cycle with tick_enable=1 and the prescaler at PRESCALE-1; the prescaler returns to 0 on the next edge.
  - The tick output is combinational on that condition.
  - When tick_enable=0, the prescaler holds and no tick occurs.
- Channel i, evaluated at each edge in priority order:
  1. count_load[i]: reload and count both take data_in. Any tick in the same cycle is ignored for channel i, and no expiry occurs.
  2. Tick, RUN[i]=1, count=1: expiry.
     - PERIODIC=1: count takes reload.
     - PERIODIC=0: count becomes 0 and RUN[i] auto-clears.
  3. Tick, RUN[i]=1, count>1: count decrements by 1.
  4. Tick, RUN[i]=1, count=0: count holds and nothing happens. Loading 0 therefore leaves the channel idle.
  5. RUN[i]=0: count holds.
- Expiry:
  - expired[i] is registered and high for exactly the one cycle after the tick cycle. It coincides with the first cycle count_out shows 0 or the reload value.
  - status[i] sets on that same edge.
- Period: a periodic channel with reload N expires every N ticks, i.e. every N*PRESCALE enabled cycles. Reload 1 expires on every tick.
- ctrl_load versus auto-clear in the same cycle: the written value wins.
- status_read: clears status bits on the next edge. If an expiry sets a bit on the same edge, the set wins and the bit reads 1 afterwards.
- Arithmetic: unsigned. Decrement never wraps, because the count=0 case holds. data_in bits above WIDTH are discarded.
- expired and status are not gated by tick_enable beyond the absence of ticks.

Decomposition:
- Shared package:
  - control bit offsets: RUN_LSB=0, PERIODIC_LSB=8.
  - the 16-bit word width constant.
  - the register offsets the top level uses to wire strobes from r_load/r_read.
- Sub-module timer_channel, instantiated NUM_CH times via a generate loop:
  - inputs: tick, load, data, run, periodic.
  - outputs: count, expire pulse, run-clear request.
- The prescaler, control register and status register stay in timer_bank.

Test Plan:
- Prescaler and one-shot: PRESCALE=50, tick_enable=1, load ch0=3, set RUN0 -> tick every 50 cycles. expired[0] pulses once 150±50 cycles later, depending on prescaler phase at load. Afterwards count0=0, RUN0=0, status_out=0x0001.
- Periodic: load ch1=2, RUN1 and PERIODIC1 set -> expired[1] every 100 cycles. count1 sequence is 2,1,2,1. status bit1 stays set until status_read, then reads 0 until the next expiry.
- Freeze: mid-count, drop tick_enable for 500 cycles -> count and prescaler hold, no tick, no expiry. Resuming continues with no lost or extra tick.
- Simultaneous events:
  - count_load on a tick cycle with count=1 -> no expiry pulse; count takes the new value.
  - status_read on an expiry edge -> flag reads 1 afterwards.
- Edge values:
  - PRESCALE=1 with reload=1 periodic -> expired held high every cycle after the first.
  - Load 0 with RUN=1 -> no expiry ever.
- Reset mid-operation: assert sysreset asynchronously between edges while ch0=7 is running -> all outputs 0 before the next edge. After release, channels stay idle until reloaded.
